// File: rtl/pid_pkg.sv
// pid_pkg: shared width derivations and signed saturation helper for the
// PID velocity controller.
//   err_w/derr_w : widths of the error and derivative terms
//   prod_w       : width of (zero-extended unsigned gain) * (signed value)
//   max_i        : integer maximum, used for the summing width
//   sat_s        : clamp a signed value into a signed field of width w
package pid_pkg;

  localparam int SHIFT_DEF = 0;

  function automatic int err_w(input int vw);
    return vw + 1;
  endfunction

  function automatic int derr_w(input int vw);
    return vw + 2;
  endfunction

  // The gain gets one extra zero bit so it multiplies as a signed operand.
  function automatic int prod_w(input int gw, input int xw);
    return gw + 1 + xw;
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v,
                                               input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pid_vel_ctrl_if.sv
// pid_vel_ctrl_if: sample-in / result-out bundle of the PID controller.
//   sample_valid, target_vel, current_vel, Kp, Ki, Kd : sample side
//   out_vel, out_valid, sat                           : result side
// master = speed-estimator / consumer side, slave = controller.
interface pid_vel_ctrl_if #(
  parameter int VW = 8,
  parameter int GW = 4,
  parameter int OW = 9
);
  logic                 sample_valid;
  logic [VW-1:0]        target_vel;
  logic [VW-1:0]        current_vel;
  logic [GW-1:0]        Kp;
  logic [GW-1:0]        Ki;
  logic [GW-1:0]        Kd;
  logic signed [OW-1:0] out_vel;
  logic                 out_valid;
  logic                 sat;

  modport master (
    output sample_valid, target_vel, current_vel, Kp, Ki, Kd,
    input  out_vel, out_valid, sat
  );

  modport slave (
    input  sample_valid, target_vel, current_vel, Kp, Ki, Kd,
    output out_vel, out_valid, sat
  );
endinterface

// File: rtl/pid_sat.sv
// pid_sat: combinational signed clamp of an IN_W-bit value into OUT_W bits.
//   d_i       : signed input
//   q_o       : clamped signed output
//   clamped_o : high when d_i was outside the OUT_W range
module pid_sat
  import pid_pkg::*;
#(
  parameter int IN_W  = 13,
  parameter int OUT_W = 12
) (
  input  logic signed [IN_W-1:0]  d_i,
  output logic signed [OUT_W-1:0] q_o,
  output logic                    clamped_o
);

  logic signed [63:0] wide;
  logic signed [63:0] clip;

  assign wide      = 64'(d_i);
  assign clip      = sat_s(wide, OUT_W);
  assign q_o       = clip[OUT_W-1:0];
  assign clamped_o = (clip != wide);

endmodule

// File: rtl/pid_vel_ctrl.sv
// pid_vel_ctrl: 3-stage PID velocity controller with integrator anti-windup.
//   CLK, RST_N : clock and async active-low reset
//   EN         : enable; low synchronously clears all state
//   bus        : pid_vel_ctrl_if.slave (samples + gains in, result out)
// S1 forms err/derr and captures gains, S2 updates the integrator and forms
// the three products, S3 sums, shifts and clamps into out_vel.
module pid_vel_ctrl
  import pid_pkg::*;
#(
  parameter int VW    = 8,
  parameter int GW    = 4,
  parameter int OW    = 9,
  parameter int IW    = 12,
  parameter int SHIFT = SHIFT_DEF
) (
  input logic           CLK,
  input logic           RST_N,
  input logic           EN,
  pid_vel_ctrl_if.slave bus
);

  localparam int EW  = err_w(VW);
  localparam int DW  = derr_w(VW);
  localparam int PPW = prod_w(GW, EW);
  localparam int IPW = prod_w(GW, IW);
  localparam int DPW = prod_w(GW, DW);
  localparam int SW  = max_i(max_i(PPW, IPW), DPW) + 2;

  logic signed [EW-1:0]  err_prev_q, err1_q;
  logic signed [DW-1:0]  derr1_q;
  logic [GW-1:0]         kp1_q, ki1_q, kd1_q;
  logic                  first_q, v1_q, v2_q;
  logic signed [IW-1:0]  integ_q;
  logic signed [PPW-1:0] p2_q;
  logic signed [IPW-1:0] i2_q;
  logic signed [DPW-1:0] d2_q;
  logic signed [OW-1:0]  out_vel_q;
  logic                  out_valid_q, sat_q;

  logic signed [EW-1:0]  err_d;
  logic signed [DW-1:0]  derr_d;
  logic signed [IW:0]    isum_d;
  logic signed [IW-1:0]  iclamp_d, i_next;
  logic                  integ_clamped_unused;
  logic                  hold_d;
  logic signed [PPW-1:0] p_d;
  logic signed [IPW-1:0] i_d;
  logic signed [DPW-1:0] d_d;
  logic signed [SW-1:0]  sum_d, res_d;
  logic signed [OW-1:0]  out_d;
  logic                  out_clamped_d;

  // S1
  assign err_d  = $signed({1'b0, bus.target_vel}) - $signed({1'b0, bus.current_vel});
  assign derr_d = first_q ? '0 : (DW'(err_d) - DW'(err_prev_q));

  // S2: integrator clamp is silent; only the output clamp drives sat.
  assign isum_d = (IW+1)'(integ_q) + (IW+1)'(err1_q);
  pid_sat #(.IN_W(IW+1), .OUT_W(IW)) u_isat (
    .d_i(isum_d), .q_o(iclamp_d), .clamped_o(integ_clamped_unused)
  );
  // Freeze the integrator while the output is pinned and err pushes further out.
  assign hold_d = sat_q && (err1_q[EW-1] == out_vel_q[OW-1]);
  assign i_next = hold_d ? integ_q : iclamp_d;
  assign p_d    = $signed({1'b0, kp1_q}) * err1_q;
  assign i_d    = $signed({1'b0, ki1_q}) * i_next;
  assign d_d    = $signed({1'b0, kd1_q}) * derr1_q;

  // S3
  assign sum_d = SW'(p2_q) + SW'(i2_q) + SW'(d2_q);
  assign res_d = sum_d >>> SHIFT;
  pid_sat #(.IN_W(SW), .OUT_W(OW)) u_osat (
    .d_i(res_d), .q_o(out_d), .clamped_o(out_clamped_d)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_prev_q <= '0; err1_q <= '0; derr1_q <= '0;
      kp1_q <= '0; ki1_q <= '0; kd1_q <= '0;
      first_q <= 1'b1; v1_q <= 1'b0; v2_q <= 1'b0;
      integ_q <= '0; p2_q <= '0; i2_q <= '0; d2_q <= '0;
      out_vel_q <= '0; out_valid_q <= 1'b0; sat_q <= 1'b0;
    end else if (!EN) begin
      err_prev_q <= '0; err1_q <= '0; derr1_q <= '0;
      kp1_q <= '0; ki1_q <= '0; kd1_q <= '0;
      first_q <= 1'b1; v1_q <= 1'b0; v2_q <= 1'b0;
      integ_q <= '0; p2_q <= '0; i2_q <= '0; d2_q <= '0;
      out_vel_q <= '0; out_valid_q <= 1'b0; sat_q <= 1'b0;
    end else begin
      v1_q <= bus.sample_valid;
      if (bus.sample_valid) begin
        err1_q     <= err_d;
        derr1_q    <= derr_d;
        kp1_q      <= bus.Kp;
        ki1_q      <= bus.Ki;
        kd1_q      <= bus.Kd;
        err_prev_q <= err_d;
        first_q    <= 1'b0;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        integ_q <= i_next;
        p2_q    <= p_d;
        i2_q    <= i_d;
        d2_q    <= d_d;
      end
      out_valid_q <= v2_q;
      if (v2_q) begin
        out_vel_q <= out_d;
        sat_q     <= out_clamped_d;
      end
    end
  end

  assign bus.out_vel   = out_vel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_pid_vel_ctrl.sv
// tb_pid_vel_ctrl: directed self-checking bench for pid_vel_ctrl.
module tb_pid_vel_ctrl;

  logic CLK = 1'b0;
  logic RST_N;
  logic EN;
  int   checks = 0;
  int   errors = 0;

  pid_vel_ctrl_if #(.VW(8), .GW(4), .OW(9)) bus ();

  pid_vel_ctrl #(.VW(8), .GW(4), .OW(9), .IW(12), .SHIFT(0)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  // Presents one sample for one cycle; returns one negedge later.
  task automatic strobe(input int kp, input int ki, input int kd,
                        input int tgt, input int cur);
    bus.Kp           = 4'(kp);
    bus.Ki           = 4'(ki);
    bus.Kd           = 4'(kd);
    bus.target_vel   = 8'(tgt);
    bus.current_vel  = 8'(cur);
    bus.sample_valid = 1'b1;
    step();
    bus.sample_valid = 1'b0;
  endtask

  task automatic clear_en();
    EN = 1'b0;
    step();
    EN = 1'b1;
  endtask

  function automatic int ov();
    return int'(bus.out_vel);
  endfunction

  initial begin
    RST_N = 1'b0;
    EN    = 1'b0;
    bus.sample_valid = 1'b0;
    bus.Kp = '0; bus.Ki = '0; bus.Kd = '0;
    bus.target_vel = '0; bus.current_vel = '0;
    step(); step();
    chk("rst_out_vel", ov(), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_sat", int'(bus.sat), 0);
    RST_N = 1'b1;
    step();
    EN = 1'b1;
    step();

    // P only: 12 * (40-45) = -60, latency 3
    strobe(12, 0, 0, 40, 45);
    chk("p_lat1_valid", int'(bus.out_valid), 0);
    step();
    chk("p_lat2_valid", int'(bus.out_valid), 0);
    step();
    chk("p_valid", int'(bus.out_valid), 1);
    chk("p_out", ov(), -60);
    chk("p_sat", int'(bus.sat), 0);
    step();
    chk("p_valid_pulse", int'(bus.out_valid), 0);
    chk("p_hold", ov(), -60);

    // Derivative: first sample derr=0, then derr=+5 -> 30
    clear_en();
    strobe(0, 0, 6, 40, 45);
    strobe(0, 0, 6, 40, 40);
    step();
    chk("d_first_valid", int'(bus.out_valid), 1);
    chk("d_first_out", ov(), 0);
    step();
    chk("d_second_valid", int'(bus.out_valid), 1);
    chk("d_second_out", ov(), 30);

    // Integral, back-to-back: 10, 20, 30
    clear_en();
    strobe(0, 1, 0, 50, 40);
    strobe(0, 1, 0, 50, 40);
    strobe(0, 1, 0, 50, 40);
    chk("i_out1", ov(), 10);
    chk("i_valid1", int'(bus.out_valid), 1);
    step();
    chk("i_out2", ov(), 20);
    chk("i_valid2", int'(bus.out_valid), 1);
    step();
    chk("i_out3", ov(), 30);
    chk("i_valid3", int'(bus.out_valid), 1);
    step();
    chk("i_valid_end", int'(bus.out_valid), 0);

    // Saturation + anti-windup
    clear_en();
    strobe(15, 1, 0, 255, 0);
    step(); step();
    chk("sat_out", ov(), 255);
    chk("sat_flag", int'(bus.sat), 1);
    step();
    chk("sat_sticky", int'(bus.sat), 1);
    chk("sat_sticky_valid", int'(bus.out_valid), 0);
    for (int k = 0; k < 3; k++) begin
      strobe(15, 1, 0, 255, 0);
      step(); step();
      chk("sat_rep_out", ov(), 255);
      chk("sat_rep_flag", int'(bus.sat), 1);
    end
    // integ held at 255: 255-255 = 0, then -255
    strobe(0, 1, 0, 0, 255);
    step(); step();
    chk("aw_rec1_valid", int'(bus.out_valid), 1);
    chk("aw_rec1_out", ov(), 0);
    chk("aw_rec1_sat", int'(bus.sat), 0);
    strobe(0, 1, 0, 0, 255);
    step(); step();
    chk("aw_rec2_out", ov(), -255);
    chk("aw_rec2_sat", int'(bus.sat), 0);

    // EN drop mid-pipeline discards the sample and zeroes out_vel
    strobe(12, 0, 0, 40, 45);
    EN = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("en_drop_valid", int'(bus.out_valid), 0);
      chk("en_drop_out", ov(), 0);
    end
    strobe(12, 0, 0, 40, 45);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("en_ignore_valid", int'(bus.out_valid), 0);
    end
    EN = 1'b1;
    strobe(0, 0, 6, 40, 45);
    step(); step();
    chk("en_first_valid", int'(bus.out_valid), 1);
    chk("en_first_derr0", ov(), 0);

    // Async reset mid-pipeline
    strobe(12, 0, 0, 40, 45);
    step(); step();
    chk("rst_pre_out", ov(), -60);
    strobe(12, 0, 0, 40, 50);
    RST_N = 1'b0;
    #1;
    chk("rst_mid_out", ov(), 0);
    chk("rst_mid_valid", int'(bus.out_valid), 0);
    chk("rst_mid_sat", int'(bus.sat), 0);
    step(); step();
    RST_N = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rst_post_valid", int'(bus.out_valid), 0);
    end
    strobe(12, 0, 0, 40, 45);
    step(); step();
    chk("rst_resume_valid", int'(bus.out_valid), 1);
    chk("rst_resume_out", ov(), -60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
